// File: rtl/layer_ctrl_pkg.sv
// Shared types and defaults for the layer controller.
// Holds the controller state encoding and the default array dimensions.
package layer_ctrl_pkg;

    localparam int DEF_M = 2;
    localparam int DEF_N = 2;

    typedef enum logic [2:0] {
        LOAD,
        CLR,
        ISSUE,
        DRAIN,
        OUTPUT
    } state_t;

    // $clog2 returns 0 for a modulus of 1; counters and addresses still need one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/layer_ctrl_if.sv
// Handshake and memory-control bundle between the layer controller and its datapath.
// The master side is the controller; the slave side is the upstream/datapath environment.
interface layer_ctrl_if #(
    parameter int AW = 2
) ();

    logic          s_valid;
    logic          s_ready;
    logic          m_ready;
    logic          m_valid;
    logic          x_wr_en;
    logic [AW-1:0] x_addr;
    logic [AW-1:0] w_addr;
    logic          mac_clr;
    logic          mac_en;

    modport master (
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_valid,
        output x_wr_en,
        output x_addr,
        output w_addr,
        output mac_clr,
        output mac_en
    );

    modport slave (
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  x_wr_en,
        input  x_addr,
        input  w_addr,
        input  mac_clr,
        input  mac_en
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear, enable and terminal-count flag.
// Wraps to zero on the enabled cycle where the count is MOD-1; clear has priority.
module mod_counter
    import layer_ctrl_pkg::*;
#(
    parameter int MOD = 2,
    parameter int W   = clog2_min1(MOD)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc  = (cnt_q == W'(MOD - 1));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/layer_ctrl.sv
// Sequencer for an M x N matrix-vector layer: loads N inputs, then for each of M rows
// clears the accumulator, issues N x/w reads, drains the last product and presents the result.
module layer_ctrl
    import layer_ctrl_pkg::*;
#(
    parameter int M  = DEF_M,
    parameter int N  = DEF_N,
    parameter int AW = clog2_min1(M * N)
) (
    input  logic          clk,
    input  logic          reset_n,
    layer_ctrl_if.master  bus
);

    localparam int KW = clog2_min1(N);
    localparam int RW = clog2_min1(M);

    state_t state_q;
    state_t state_d;
    logic   s_ready_q;
    logic   s_ready_d;
    logic   mac_en_q;
    logic   mac_en_d;

    logic [KW-1:0] k_cnt;
    logic [KW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          k_tc;
    logic          col_tc;
    logic          row_tc;

    logic load_hs;
    logic out_hs;

    assign load_hs = bus.s_valid && s_ready_q;
    assign out_hs  = (state_q == OUTPUT) && bus.m_ready;

    mod_counter #(.MOD(N), .W(KW)) u_k_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .en      (load_hs),
        .cnt     (k_cnt),
        .tc      (k_tc)
    );

    mod_counter #(.MOD(N), .W(KW)) u_col_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_q == CLR),
        .en      (state_q == ISSUE),
        .cnt     (col_cnt),
        .tc      (col_tc)
    );

    mod_counter #(.MOD(M), .W(RW)) u_row_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (load_hs && k_tc),
        .en      (out_hs),
        .cnt     (row_cnt),
        .tc      (row_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (load_hs && k_tc) state_d = CLR;
            CLR:     state_d = ISSUE;
            ISSUE:   if (col_tc) state_d = DRAIN;
            DRAIN:   state_d = OUTPUT;
            OUTPUT:  if (bus.m_ready) state_d = row_tc ? LOAD : CLR;
            default: state_d = LOAD;
        endcase
    end

    // s_ready is a flop so it stays low through reset and never follows s_valid combinationally.
    // mac_en lags ISSUE by one cycle to line up with the registered memory read data.
    always_comb begin
        s_ready_d = (state_d == LOAD);
        mac_en_d  = (state_q == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= LOAD;
            s_ready_q <= 1'b0;
            mac_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            mac_en_q  <= mac_en_d;
        end
    end

    always_comb begin
        bus.x_addr = '0;
        bus.w_addr = '0;
        if (state_q == LOAD) begin
            bus.x_addr = AW'(k_cnt);
        end else if (state_q == ISSUE) begin
            bus.x_addr = AW'(col_cnt);
            bus.w_addr = AW'(row_cnt) * AW'(N) + AW'(col_cnt);
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.x_wr_en = load_hs;
    assign bus.m_valid = (state_q == OUTPUT);
    assign bus.mac_clr = (state_q == CLR);
    assign bus.mac_en  = mac_en_q;

endmodule

// File: doc/layer_ctrl.md
LAYER_CTRL -- requirements
Module: layer_ctrl

Interface
REQ-001 Parameter: M, default 2, number of output neurons (rows).
REQ-002 Parameter: N, default 2, number of input values per vector (columns).
REQ-003 Parameter: AW, default $clog2(M*N) (minimum 1), address width for x and weight memories.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 s_valid  in  1  upstream input value valid.
REQ-007 s_ready  out  1  controller accepts an input value this cycle.
REQ-008 m_ready  in  1  downstream accepts output.
REQ-009 m_valid  out  1  datapath accumulator holds a finished output.
REQ-010 x_wr_en  out  1  write the current data_in into x memory at x_addr.
REQ-011 x_addr  out  AW  x memory read/write address.
REQ-012 w_addr  out  AW  weight ROM read address.
REQ-013 mac_clr  out  1  clear the accumulator (one-cycle pulse).
REQ-014 mac_en  out  1  accumulate the product of the x and w memory read data.

Function
REQ-015 States: LOAD, CLR, ISSUE, DRAIN, OUTPUT; all outputs are registered or decoded from state and counters only, with no combinational path from s_valid or m_ready to s_ready or m_valid.
REQ-016 LOAD behaviour:
- s_ready=1.
- x_wr_en = s_valid && s_ready.
- x_addr = load counter k.
- k increments on each handshake.
REQ-017 LOAD exit: on the handshake with k==N-1, k clears to 0, row clears to 0, and the next state is CLR.
REQ-018 CLR: mac_clr=1 for exactly one cycle; col=0; the next state is ISSUE.
REQ-019 ISSUE behaviour:
- x_addr=col, w_addr=row*N+col.
- col increments each cycle.
- After the cycle with col==N-1, the next state is DRAIN.
- ISSUE lasts N cycles.
REQ-020 mac_en is the one-cycle-delayed copy of the ISSUE indicator, matching the 1-cycle memory read latency, so mac_en is high for exactly N cycles per row.
REQ-021 DRAIN: one cycle allowing the final accumulate to land; the next state is OUTPUT.
REQ-022 OUTPUT: m_valid=1 and is held until m_ready is sampled high.
REQ-023 On the OUTPUT handshake, the next state is CLR with row+1 if row<M-1; otherwise it is LOAD.
REQ-024 s_ready=0 and x_wr_en=0 in every state except LOAD; s_valid is ignored there and no input is consumed.
REQ-025 m_valid=0 outside OUTPUT; m_ready is ignored outside OUTPUT.
REQ-026 The minimum per-vector cycle count, with m_ready held high, is N + M*(N+3); this is 12 for M=2, N=2.
REQ-027 Counters never exceed their bounds: k, col < N and row < M; wrap to 0 only at the transitions stated above.
REQ-028 x_addr and w_addr are 0 whenever not driven by LOAD or ISSUE.

Reset
REQ-029 While reset_n=0 at a rising edge, the following are forced to reset values on the next edge, including mid-operation:
- State returns to LOAD.
- k, col and row are 0.
- mac_clr, mac_en, m_valid, x_wr_en, x_addr and w_addr are 0.
REQ-030 s_ready is 0 while reset_n=0 and becomes 1 in the first cycle after reset_n returns high.
REQ-031 A partially loaded vector or partially computed row is discarded on reset; no m_valid is produced for it.

Structure
REQ-032 Shared package layer_ctrl_pkg holds the state enum typedef (LOAD, CLR, ISSUE, DRAIN, OUTPUT) and the default M/N constants.
REQ-033 One sub-module, mod_counter (parameterised modulus, enable, clear, terminal-count flag), is instantiated for k, col and row.

Verification
REQ-034 Reset, then s_valid=1 constantly and m_ready=1 constantly, M=2, N=2 -> waveform requirements:
- x_wr_en at x_addr 0 then 1.
- mac_clr one cycle.
- w_addr 0,1 then 2,3.
- mac_en pulses 2 per row.
- m_valid pulses 2, first input-to-second-output period 12 cycles.
REQ-035 m_ready=0 for 5 cycles during OUTPUT -> m_valid stays 1, state and row are unchanged, and the next row begins only after the handshake.
REQ-036 s_valid asserted during ISSUE/OUTPUT -> s_ready=0 and no x_wr_en; the value is accepted in LOAD only.
REQ-037 reset_n driven 0 during the row-1 ISSUE state -> next cycle state=LOAD and all outputs are 0; the following vector computes correctly from row 0.
REQ-038 Random s_valid/m_ready, each with 50% probability, for 1000 vectors -> check:
- exactly N x_wr_en and M m_valid per vector;
- mac_en count = M*N per vector;
- no mac_en outside the cycle after ISSUE.
